param_bus_datapath: RTL and testbench

- Parametrised successor to the fixed 16-register bus datapath.
- Contains a register file of configurable depth and width, Y/Z/HI/LO ALU staging registers and a single shared bus.
- A micro-sequencer executes one register-to-register operation per request through the bus. Sequence: Y ← Ra, then Z ← Y op Rb, then Rd ← Z.
- Adds a multi-cycle shift-add multiplier writing HI/LO, an external load port for bring-up, and a combinational debug read port.

---
 rtl/datapath_pkg.sv | 28 ++
 rtl/seq_multiplier.sv | 54 +++++
 rtl/param_bus_datapath.sv | 167 ++++++++++++++++
 tb/tb_param_bus_datapath.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared opcode values and sequencer state encoding for the bus datapath.
// Pure declarations; no timing or flow control of its own.
package datapath_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_SHRA = 4'h6;
    localparam logic [3:0] OP_ROL  = 4'h7;
    localparam logic [3:0] OP_NEG  = 4'h8;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_MUL  = 4'hA;
    localparam logic [3:0] OP_MFHI = 4'hB;
    localparam logic [3:0] OP_MFLO = 4'hC;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_Y,
        EXEC,
        MUL_WAIT,
        WRITE,
        FINISH
    } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier, one partial product per cycle; finished pulses on the WIDTH-th busy cycle.
// No backpressure: start restarts it; product carries the final result only while finished is high.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               finished,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;

    // Add into the upper half, then shift the whole accumulator right one bit.
    assign addend   = mplier[0] ? mcand : '0;
    assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    assign product  = {sum, acc[WIDTH-1:1]};
    assign finished = busy && (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            cnt    <= '0;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= product;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (finished) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/param_bus_datapath.sv
// Register file + Y/Z/HI/LO around one shared bus; ALU/MF ops finish 4 cycles after accept, MUL WIDTH+3, illegal 3.
// op_ready is low for the whole operation and while ext_we loads a register; requests are taken only in IDLE.
module param_bus_datapath
    import datapath_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int REG_COUNT = 16,
    parameter int SEL_W     = $clog2(REG_COUNT),
    parameter int ZERO_R0   = 0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op_code,
    input  logic [SEL_W-1:0] ra,
    input  logic [SEL_W-1:0] rb,
    input  logic [SEL_W-1:0] rd,
    output logic             done,
    output logic             op_err,
    input  logic             ext_we,
    input  logic [SEL_W-1:0] ext_sel,
    input  logic [WIDTH-1:0] ext_data,
    input  logic [SEL_W+1:0] dbg_sel,
    output logic [WIDTH-1:0] dbg_data,
    output logic [WIDTH-1:0] bus_out
);

    localparam int               SH_W    = $clog2(WIDTH);
    localparam logic [SH_W:0]    WIDTH_L = (SH_W + 1)'(WIDTH);
    localparam logic [SEL_W+1:0] DBG_Z   = (SEL_W + 2)'(REG_COUNT);
    localparam logic [SEL_W+1:0] DBG_HI  = (SEL_W + 2)'(REG_COUNT + 1);
    localparam logic [SEL_W+1:0] DBG_LO  = (SEL_W + 2)'(REG_COUNT + 2);
    localparam logic [SEL_W+1:0] DBG_Y   = (SEL_W + 2)'(REG_COUNT + 3);

    state_t             state;
    logic [3:0]         op_q;
    logic [SEL_W-1:0]   ra_q, rb_q, rd_q;
    logic [WIDTH-1:0]   regs [REG_COUNT];
    logic [WIDTH-1:0]   y_q, z_q, hi_q, lo_q;
    logic [WIDTH-1:0]   bus, alu_res;
    logic [SH_W-1:0]    shamt;
    logic [SH_W:0]      rol_back;
    logic               op_legal, ext_ok, rd_ok;
    logic               mul_start, mul_busy, mul_finished;
    logic [2*WIDTH-1:0] mul_product;

    // R0 stays at its reset value of 0 when hard-wired, so reads need no special case.
    assign ext_ok   = !((ZERO_R0 != 0) && (ext_sel == '0));
    assign rd_ok    = !((ZERO_R0 != 0) && (rd_q == '0));
    assign op_legal = (op_q <= OP_MFLO);
    assign op_ready = (state == IDLE) && !ext_we;
    assign done     = (state == FINISH);
    assign bus_out  = bus;
    assign shamt    = bus[SH_W-1:0];
    assign rol_back = WIDTH_L - {1'b0, shamt};
    assign mul_start = (state == EXEC) && (op_q == OP_MUL);

    always_comb begin
        bus = '0;
        case (state)
            LOAD_Y:  bus = regs[ra_q];
            EXEC:    bus = regs[rb_q];
            WRITE:   bus = z_q;
            default: bus = '0;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_ADD:  alu_res = y_q + bus;
            OP_SUB:  alu_res = y_q - bus;
            OP_AND:  alu_res = y_q & bus;
            OP_OR:   alu_res = y_q | bus;
            OP_SHL:  alu_res = y_q << shamt;
            OP_SHR:  alu_res = y_q >> shamt;
            OP_SHRA: alu_res = $signed(y_q) >>> shamt;
            OP_ROL:  alu_res = (y_q << shamt) | (y_q >> rol_back);
            OP_NEG:  alu_res = '0 - bus;
            OP_NOT:  alu_res = ~bus;
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        dbg_data = '0;
        if (dbg_sel < DBG_Z)        dbg_data = regs[dbg_sel[SEL_W-1:0]];
        else if (dbg_sel == DBG_Z)  dbg_data = z_q;
        else if (dbg_sel == DBG_HI) dbg_data = hi_q;
        else if (dbg_sel == DBG_LO) dbg_data = lo_q;
        else if (dbg_sel == DBG_Y)  dbg_data = y_q;
    end

    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clock    (clock),
        .clear    (clear),
        .start    (mul_start),
        .a        (y_q),
        .b        (bus),
        .busy     (mul_busy),
        .finished (mul_finished),
        .product  (mul_product)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state  <= IDLE;
            op_q   <= '0;
            ra_q   <= '0;
            rb_q   <= '0;
            rd_q   <= '0;
            y_q    <= '0;
            z_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            op_err <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else begin
            op_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (ext_we) begin
                        if (ext_ok) regs[ext_sel] <= ext_data;
                    end else if (op_valid) begin
                        op_q  <= op_code;
                        ra_q  <= ra;
                        rb_q  <= rb;
                        rd_q  <= rd;
                        state <= LOAD_Y;
                    end
                end
                LOAD_Y: begin
                    y_q   <= bus;
                    state <= EXEC;
                end
                EXEC: begin
                    if (!op_legal) begin
                        op_err <= 1'b1;
                        state  <= FINISH;
                    end else if (op_q == OP_MUL) begin
                        state <= MUL_WAIT;
                    end else begin
                        z_q   <= alu_res;
                        state <= WRITE;
                    end
                end
                MUL_WAIT: begin
                    if (mul_busy && mul_finished) begin
                        {hi_q, lo_q} <= mul_product;
                        state        <= FINISH;
                    end
                end
                WRITE: begin
                    if (rd_ok) regs[rd_q] <= bus;
                    state <= FINISH;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_bus_datapath.sv
// Directed vector table, hand-built corner sequences and random ops for param_bus_datapath,
// checked against a per-operation reference model for a plain build and a ZERO_R0 build.
module tb_param_bus_datapath;

    logic        clock, clear, op_valid, ext_we;
    logic [3:0]  op_code, ra, rb, rd, ext_sel;
    logic [31:0] ext_data;
    logic [5:0]  dbg_sel;
    logic        op_ready, done, op_err, op_ready_z, done_z, op_err_z;
    logic [31:0] dbg_data, bus_out, dbg_data_z, bus_out_z;

    int total, bad;

    // Model state; index 0 = plain build, 1 = ZERO_R0 build.
    logic [31:0] mr [2][16];
    logic [31:0] my [2];
    logic [31:0] mz [2];
    logic [31:0] mhi [2];
    logic [31:0] mlo [2];

    typedef struct {
        logic [3:0]  op, a_i, b_i, d_i;
        logic [31:0] a, b, exp;
    } vec_t;
    vec_t vt [13];

    param_bus_datapath dut (
        .clock(clock), .clear(clear), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .ra(ra), .rb(rb), .rd(rd), .done(done), .op_err(op_err),
        .ext_we(ext_we), .ext_sel(ext_sel), .ext_data(ext_data),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data), .bus_out(bus_out)
    );

    param_bus_datapath #(.ZERO_R0(1)) dut_z (
        .clock(clock), .clear(clear), .op_valid(op_valid), .op_ready(op_ready_z),
        .op_code(op_code), .ra(ra), .rb(rb), .rd(rd), .done(done_z), .op_err(op_err_z),
        .ext_we(ext_we), .ext_sel(ext_sel), .ext_data(ext_data),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data_z), .bus_out(bus_out_z)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) mr[k][i] = '0;
            my[k] = '0; mz[k] = '0; mhi[k] = '0; mlo[k] = '0;
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input int k);
        int s;
        logic [31:0] r;
        s = int'(b[4:0]);
        case (op)
            4'h0: r = a + b;
            4'h1: r = a - b;
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a << s;
            4'h5: r = a >> s;
            4'h6: r = $signed(a) >>> s;
            4'h7: begin
                r = a;
                repeat (s) r = {r[30:0], r[31]};
            end
            4'h8: r = 32'd0 - b;
            4'h9: r = ~b;
            4'hB: r = mhi[k];
            4'hC: r = mlo[k];
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] exp_dbg(input int k, input int s);
        if (s < 16) return mr[k][s];
        case (s)
            16: return mz[k];
            17: return mhi[k];
            18: return mlo[k];
            19: return my[k];
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_all(input string tag);
        int sel;
        for (int s = 0; s < 22; s++) begin
            sel = (s == 21) ? 63 : s;
            dbg_sel = 6'(sel);
            #1;
            check($sformatf("%s dbg%0d", tag, sel), dbg_data, exp_dbg(0, sel));
            check($sformatf("%s dbgz%0d", tag, sel), dbg_data_z, exp_dbg(1, sel));
        end
    endtask

    // Register load with a competing op request that must be refused.
    task automatic ext_wr(input logic [3:0] s, input logic [31:0] d);
        @(negedge clock);
        ext_we = 1; ext_sel = s; ext_data = d;
        op_valid = 1; op_code = 4'h0;
        #1;
        check("ready_during_ext", {31'b0, op_ready}, 32'd0);
        @(negedge clock);
        ext_we = 0; op_valid = 0;
        mr[0][s] = d;
        if (s != 4'd0) mr[1][s] = d;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [3:0] a_i, input logic [3:0] b_i,
                          input logic [3:0] d_i, input bit mid_ext);
        int n, lat, rdy_low;
        bit got, ill;
        logic [31:0] va, vb, a, b;
        ill = (op > 4'hC);
        lat = ill ? 3 : ((op == 4'hA) ? 35 : 4);
        va  = mr[0][a_i];
        vb  = mr[0][b_i];
        @(negedge clock);
        check("ready_idle", {31'b0, op_ready}, 32'd1);
        check("done_idle", {31'b0, done}, 32'd0);
        check("bus_idle", bus_out, 32'd0);
        op_valid = 1; op_code = op; ra = a_i; rb = b_i; rd = d_i;
        n = 0; rdy_low = 0; got = 0;
        while (!got && n < 60) begin
            @(negedge clock);
            n++;
            if (!op_ready) rdy_low++;
            if (n == 1) check("bus_load_y", bus_out, va);
            if (n == 2) check("bus_exec", bus_out, vb);
            if (done) got = 1;
            if (n == 1) begin
                op_valid = 0;
                op_code = 4'($urandom); ra = 4'($urandom); rb = 4'($urandom); rd = 4'($urandom);
                if (mid_ext) begin
                    ext_we = 1; ext_sel = 4'd9; ext_data = 32'hDEAD_BEEF;
                end
            end
            if (n == 2) ext_we = 0;
        end
        ext_we = 0;
        check("done_seen", {31'b0, got}, 32'd1);
        check("latency", 32'(n), 32'(lat));
        check("ready_low", 32'(rdy_low), 32'(n));
        check("op_err", {31'b0, op_err}, {31'b0, ill});
        check("done_z", {31'b0, done_z}, 32'd1);
        check("op_err_z", {31'b0, op_err_z}, {31'b0, ill});
        for (int k = 0; k < 2; k++) begin
            a = mr[k][a_i];
            b = mr[k][b_i];
            my[k] = a;
            if (op == 4'hA) begin
                {mhi[k], mlo[k]} = {32'd0, a} * {32'd0, b};
            end else if (!ill) begin
                mz[k] = ref_alu(op, a, b, k);
                if (!(k == 1 && d_i == 4'd0)) mr[k][d_i] = mz[k];
            end
        end
        check_all($sformatf("op%0h", op));
    endtask

    initial begin
        logic [3:0] rop;
        total = 0; bad = 0;
        clock = 0; clear = 1; op_valid = 0; ext_we = 0;
        op_code = 0; ra = 0; rb = 0; rd = 0; ext_sel = 0; ext_data = 0; dbg_sel = 0;
        model_clear();

        vt[0]  = '{4'h0, 4'd3, 4'd4, 4'd5,  32'h0000_0005, 32'h0000_0007, 32'h0000_000C};
        vt[1]  = '{4'h6, 4'd1, 4'd2, 4'd6,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
        vt[2]  = '{4'h5, 4'd1, 4'd2, 4'd6,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
        vt[3]  = '{4'h7, 4'd1, 4'd2, 4'd6,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001};
        vt[4]  = '{4'h8, 4'd1, 4'd2, 4'd6,  32'h8000_0000, 32'h0000_0004, 32'hFFFF_FFFC};
        vt[5]  = '{4'h1, 4'd3, 4'd4, 4'd8,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
        vt[6]  = '{4'h2, 4'd3, 4'd4, 4'd8,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234};
        vt[7]  = '{4'h3, 4'd3, 4'd4, 4'd8,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF};
        vt[8]  = '{4'h4, 4'd3, 4'd4, 4'd8,  32'h0000_0001, 32'h0000_0023, 32'h0000_0008};
        vt[9]  = '{4'h9, 4'd3, 4'd4, 4'd8,  32'h1234_5678, 32'h0000_FFFF, 32'hFFFF_0000};
        vt[10] = '{4'h6, 4'd3, 4'd4, 4'd8,  32'h4000_0000, 32'h0000_0001, 32'h2000_0000};
        vt[11] = '{4'h7, 4'd3, 4'd4, 4'd8,  32'h8000_0001, 32'h0000_0000, 32'h8000_0001};
        vt[12] = '{4'h0, 4'd10, 4'd10, 4'd10, 32'h0000_0003, 32'h0000_0003, 32'h0000_0006};

        repeat (2) @(negedge clock);
        clear = 0;
        #1;
        check("reset_ready", {31'b0, op_ready}, 32'd1);
        check("reset_ready_z", {31'b0, op_ready_z}, 32'd1);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_err", {31'b0, op_err}, 32'd0);
        check("reset_bus", bus_out, 32'd0);
        check("reset_bus_z", bus_out_z, 32'd0);
        check_all("reset");

        for (int i = 0; i < 13; i++) begin
            ext_wr(vt[i].a_i, vt[i].a);
            ext_wr(vt[i].b_i, vt[i].b);
            run_op(vt[i].op, vt[i].a_i, vt[i].b_i, vt[i].d_i, 1'b0);
            dbg_sel = {2'b00, vt[i].d_i};
            #1;
            check($sformatf("vec%0d", i), dbg_data, vt[i].exp);
        end

        // Multiply, then move HI out through the bus.
        ext_wr(4'd1, 32'hFFFF_FFFF);
        ext_wr(4'd2, 32'h0000_0002);
        run_op(4'hA, 4'd1, 4'd2, 4'd0, 1'b0);
        dbg_sel = 6'd17; #1;
        check("mul_hi", dbg_data, 32'h0000_0001);
        dbg_sel = 6'd18; #1;
        check("mul_lo", dbg_data, 32'hFFFF_FFFE);
        run_op(4'hB, 4'd1, 4'd2, 4'd7, 1'b0);
        dbg_sel = 6'd7; #1;
        check("mfhi_r7", dbg_data, 32'h0000_0001);

        // Illegal opcode with a refused mid-operation load.
        run_op(4'hE, 4'd1, 4'd2, 4'd5, 1'b1);
        dbg_sel = 6'd9; #1;
        check("ext_mid_ignored", dbg_data, mr[0][9]);

        // Hard-wired R0 in the ZERO_R0 build.
        ext_wr(4'd0, 32'h0000_1234);
        dbg_sel = 6'd0; #1;
        check("r0_plain", dbg_data, 32'h0000_1234);
        check("r0_zero_ext", dbg_data_z, 32'd0);
        ext_wr(4'd3, 32'd1);
        ext_wr(4'd4, 32'd2);
        run_op(4'h0, 4'd3, 4'd4, 4'd0, 1'b0);
        dbg_sel = 6'd0; #1;
        check("r0_zero_add", dbg_data_z, 32'd0);
        ext_wr(4'd2, 32'd3);
        run_op(4'h1, 4'd0, 4'd2, 4'd1, 1'b0);
        dbg_sel = 6'd1; #1;
        check("r0_zero_sub", dbg_data_z, 32'hFFFF_FFFD);

        // Asynchronous clear in the middle of a multiply.
        ext_wr(4'd1, 32'hFFFF_0001);
        ext_wr(4'd2, 32'h0000_0013);
        @(negedge clock);
        op_valid = 1; op_code = 4'hA; ra = 4'd1; rb = 4'd2; rd = 4'd0;
        @(negedge clock);
        op_valid = 0;
        repeat (9) begin
            @(negedge clock);
            check("mul_no_done", {31'b0, done}, 32'd0);
        end
        check("bus_mul_wait", bus_out, 32'd0);
        clear = 1;
        #1;
        model_clear();
        check("clr_ready", {31'b0, op_ready}, 32'd1);
        check("clr_done", {31'b0, done}, 32'd0);
        check("clr_err", {31'b0, op_err}, 32'd0);
        check_all("clear_mid");
        @(negedge clock);
        clear = 0;
        #1;
        check("post_clr_ready", {31'b0, op_ready}, 32'd1);
        repeat (3) begin
            @(negedge clock);
            check("post_clr_no_done", {31'b0, done}, 32'd0);
            check("post_clr_no_done_z", {31'b0, done_z}, 32'd0);
        end
        ext_wr(4'd3, 32'd5);
        ext_wr(4'd4, 32'd7);
        run_op(4'h0, 4'd3, 4'd4, 4'd5, 1'b0);
        dbg_sel = 6'd5; #1;
        check("post_clr_add", dbg_data, 32'h0000_000C);

        for (int i = 0; i < 50; i++) begin
            if ($urandom_range(0, 3) == 0) ext_wr(4'($urandom), $urandom);
            rop = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(13, 15)) : 4'($urandom_range(0, 12));
            run_op(rop, 4'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 7) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
